// File: rtl/signed_sort_pkg.sv
// Shared types and defaults for the signed block sorter.
`timescale 1ns/1ps
package signed_sort_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SORT   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 8;

  // Index width for a block of `depth` samples; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(DEPTH_DEF);

endpackage

// File: rtl/signed_cmp_unit.sv
// Combinational two's-complement magnitude comparator (gt/lt/eq of a versus b).
`timescale 1ns/1ps
module signed_cmp_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = $signed(a) >  $signed(b);
  assign lt = $signed(a) <  $signed(b);
  assign eq = (a == b);

endmodule

// File: rtl/signed_sort_ctrl.sv
// Loads DEPTH signed samples, bubble-sorts them in place with one shared
// comparator, then streams them out. Optional macro: SORT_EARLY_EXIT_EN.
`timescale 1ns/1ps
module signed_sort_ctrl
  import signed_sort_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             descending,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int            IW       = idx_width(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_J   = IW'(DEPTH - 2);

  state_t           state, next_state;
  logic [IW-1:0]    wr_idx, rd_idx, j, pass;
  logic [IW-1:0]    jp1;
  logic             swap_flag, desc_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             gt, lt, eq;
  logic             do_swap, pass_end, sort_done;
  logic             in_fire, out_fire;

  assign jp1   = j + IW'(1);
  assign cmp_a = mem[j];
  assign cmp_b = mem[jp1];

  signed_cmp_unit #(.WIDTH(WIDTH)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (gt),
    .lt (lt),
    .eq (eq)
  );

  // Equal pairs never swap, which keeps the sort stable.
  assign do_swap  = (state == SORT) && !eq && (desc_q ? lt : gt);
  assign pass_end = (j == LAST_J);

`ifdef SORT_EARLY_EXIT_EN
  // A pass with no swap (including this cycle's compare) means the block is ordered.
  assign sort_done = pass_end && ((pass == LAST_J) || !(swap_flag || do_swap));
`else
  assign sort_done = pass_end && (pass == LAST_J);
`endif

  assign in_fire  = (state == LOAD) && in_valid;
  assign out_fire = (state == UNLOAD) && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    busy       = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx == LAST_IDX)) next_state = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_done) next_state = UNLOAD;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_data  = mem[rd_idx];
        out_last  = (rd_idx == LAST_IDX);
        if (out_ready && out_last) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      j         <= '0;
      pass      <= '0;
      swap_flag <= 1'b0;
      desc_q    <= 1'b0;
    end else begin
      if (in_fire) begin
        wr_idx <= wr_idx + IW'(1);
        if (wr_idx == LAST_IDX) begin
          desc_q    <= descending;
          j         <= '0;
          pass      <= '0;
          swap_flag <= 1'b0;
        end
      end
      if (state == SORT) begin
        if (pass_end) begin
          j         <= '0;
          pass      <= pass + IW'(1);
          swap_flag <= 1'b0;
        end else begin
          j <= jp1;
          if (do_swap) swap_flag <= 1'b1;
        end
      end
      if (out_fire) begin
        if (rd_idx == LAST_IDX) begin
          rd_idx <= '0;
          wr_idx <= '0;
        end else begin
          rd_idx <= rd_idx + IW'(1);
        end
      end
    end
  end

  // NOTE: sample storage has no reset; it is always rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_idx] <= in_data;
    end else if (do_swap) begin
      mem[j]   <= cmp_b;
      mem[jp1] <= cmp_a;
    end
  end

endmodule

// File: tb/tb_signed_sort_ctrl.sv
// Scoreboard bench for signed_sort_ctrl: driver queues expected outputs, a
// negedge monitor pops and compares each output transfer.
`timescale 1ns/1ps
module tb_signed_sort_ctrl;

  typedef logic signed [3:0] blk_t [8];
  typedef int tag_t [8];
  typedef struct {
    logic signed [3:0] data;
    logic              last;
    int                tag;
  } exp_t;

`ifdef SORT_EARLY_EXIT_EN
  localparam int FULL_BUSY = -1;
  localparam int PRE_BUSY  = 7;
`else
  localparam int FULL_BUSY = 49;
  localparam int PRE_BUSY  = 49;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       descending;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         busy_cnt = 0;
  logic       stalled  = 1'b0;
  logic [3:0] held_data;
  logic       held_last;

  signed_sort_ctrl #(.WIDTH(4), .DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .descending (descending),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
  end

  // Monitor: compares every output transfer and stall stability.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (stalled) begin
        check("stall_data", out_data, held_data);
        check("stall_last", out_last, held_last);
      end
      stalled = 1'b0;
      if (out_valid === 1'b1) begin
        check("in_ready_during_unload", in_ready, 0);
        if (out_ready === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("out_data[tag%0d]", e.tag), $signed(out_data), e.data);
            check($sformatf("out_last[tag%0d]", e.tag), out_last, e.last);
          end
        end else begin
          stalled   = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end
      end
    end
  end

  task automatic load_block(input string name, input blk_t vin, input logic desc);
    descending = desc;
    for (int i = 0; i < 8; i++) begin
      check({name, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      in_data  = vin[i];
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    in_data    = '0;
    descending = ~desc;  // must already be latched
  endtask

  task automatic run_block(input string name, input blk_t vin, input blk_t vexp,
                           input tag_t tags, input logic desc,
                           input int exp_busy, input bit bp);
    bit seen;
    int k;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) sb.push_back('{vexp[i], (i == 7), tags[i]});
    load_block(name, vin, desc);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check({name, "_unload_reached"}, seen, 1);
    if (exp_busy >= 0) check({name, "_busy_cycles"}, busy_cnt, exp_busy);
    @(posedge clk); #1;
    k = 0;
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      if (bp) out_ready = (k < 2) ? 1'b1 : (k < 7) ? 1'b0 : k[0];
      k++;
      @(posedge clk); #1;
    end
    check({name, "_drained"}, sb.size(), 0);
    out_ready = 1'b1;
    check({name, "_in_ready_after"}, in_ready, 1);
    check({name, "_out_valid_after"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; descending = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsorted ascending block
    run_block("t1", '{3, -1, 7, -8, 0, 5, -2, 1}, '{-8, -2, -1, 0, 1, 3, 5, 7},
              '{3, 6, 1, 4, 7, 0, 5, 2}, 1'b0, FULL_BUSY, 1'b0);
    // Descending with duplicate zeros at positions 2 and 5
    run_block("t2", '{3, -1, 0, -8, 7, 0, 5, 1}, '{7, 5, 3, 1, 0, 0, -1, -8},
              '{4, 6, 0, 7, 2, 5, 1, 3}, 1'b1, FULL_BUSY, 1'b0);
    // Signed extremes: 7 must never precede -1
    run_block("t3", '{-8, -8, -8, 7, 7, 7, -1, 0}, '{-8, -8, -8, -1, 0, 7, 7, 7},
              '{0, 1, 2, 6, 7, 3, 4, 5}, 1'b0, FULL_BUSY, 1'b0);
    // Already-ordered block: latency depends on early exit
    run_block("t3_presorted", '{-8, -7, -6, -5, -4, -3, -2, -1},
              '{-8, -7, -6, -5, -4, -3, -2, -1},
              '{0, 1, 2, 3, 4, 5, 6, 7}, 1'b0, PRE_BUSY, 1'b0);
    // Output backpressure
    run_block("t4", '{2, -3, 6, -5, 1, -7, 4, 0}, '{-7, -5, -3, 0, 1, 2, 4, 6},
              '{5, 3, 1, 7, 4, 0, 6, 2}, 1'b0, FULL_BUSY, 1'b1);

    // Reset in the middle of a sort
    busy_cnt = 0;
    load_block("t5_abort", '{3, -1, 7, -8, 0, 5, -2, 1}, 1'b0);
    reached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      @(negedge clk); #1;
      if (busy_cnt >= 10) reached = 1'b1;
    end
    check("t5_sort_cycle10_reached", reached, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_in_ready", in_ready, 1);
    check("t5_async_busy", busy, 0);
    check("t5_async_out_valid", out_valid, 0);
    sb.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_block("t5_fresh", '{-1, -2, -3, -4, 4, 3, 2, 1}, '{4, 3, 2, 1, -1, -2, -3, -4},
              '{4, 5, 6, 7, 0, 1, 2, 3}, 1'b1, FULL_BUSY, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
